// File: rtl/bp_stream_mmio_arb_pkg.sv
// bp_stream_mmio_arb_pkg: shared defaults and round-robin index helpers
package bp_stream_mmio_arb_pkg;

    localparam int bp_num_req_default_lp   = 2;
    localparam int bp_data_width_default_lp = 32;
    localparam int bp_pkt_words_default_lp  = 2;
    localparam int bp_rsp_words_default_lp  = 2;
    localparam int bp_order_els_default_lp  = 16;

    // (p + k) mod n for p < n, k <= n; avoids a real divider in the scan
    function automatic int bp_rr_add(input int p, input int k, input int n);
        return (p + k >= n) ? p + k - n : p + k;
    endfunction

    function automatic int bp_rr_inc(input int p, input int n);
        return bp_rr_add(p, 1, n);
    endfunction

endpackage

// File: rtl/bp_stream_mmio_arb_fifo.sv
// bsg_fifo_1r1w_small: small circular FIFO, valid/ready in, valid/yumi out
module bsg_fifo_1r1w_small
    import bp_stream_mmio_arb_pkg::*;
#(
    parameter int width_p = 1,
    parameter int els_p   = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int lg_cnt_lp = $clog2(els_p + 1);

    logic [width_p-1:0]   mem_r [els_p];
    logic [lg_els_lp-1:0] wptr_r, rptr_r;
    logic [lg_cnt_lp-1:0] cnt_r;
    logic                 enq, deq;

    // fullness comes only from the registered count, never from a same-cycle pop
    always_comb begin
        ready_o = cnt_r != lg_cnt_lp'(els_p);
        v_o     = cnt_r != '0;
        enq     = v_i & ready_o;
        deq     = yumi_i & v_o;
        data_o  = mem_r[rptr_r];
    end

    // storage needs no reset; occupancy is tracked by the pointers and count
    always_ff @(posedge clk_i) begin
        if (enq)
            mem_r[wptr_r] <= data_i;
    end

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
            cnt_r  <= '0;
        end else begin
            if (enq)
                wptr_r <= lg_els_lp'(bp_rr_inc(int'(wptr_r), els_p));
            if (deq)
                rptr_r <= lg_els_lp'(bp_rr_inc(int'(rptr_r), els_p));
            cnt_r <= cnt_r + lg_cnt_lp'(enq) - lg_cnt_lp'(deq);
        end
    end

endmodule

// File: rtl/bp_stream_mmio_arb.sv
// bp_stream_mmio_arb: round-robin packet arbiter onto one host stream with in-order response steering
module bp_stream_mmio_arb
    import bp_stream_mmio_arb_pkg::*;
#(
    parameter int num_req_p           = bp_num_req_default_lp,
    parameter int stream_data_width_p = bp_data_width_default_lp,
    parameter int pkt_words_p         = bp_pkt_words_default_lp,
    parameter int rsp_words_p         = bp_rsp_words_default_lp,
    parameter int order_els_p         = bp_order_els_default_lp
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic [num_req_p-1:0]                     req_v_i,
    input  logic [num_req_p*stream_data_width_p-1:0] req_data_i,
    input  logic [num_req_p-1:0]                     req_rsp_i,
    output logic [num_req_p-1:0]                     req_yumi_o,
    output logic                                     host_v_o,
    output logic [stream_data_width_p-1:0]           host_data_o,
    input  logic                                     host_ready_and_i,
    input  logic                                     host_v_i,
    input  logic [stream_data_width_p-1:0]           host_data_i,
    output logic                                     host_ready_o,
    output logic [num_req_p-1:0]                     rsp_v_o,
    output logic [stream_data_width_p-1:0]           rsp_data_o,
    input  logic [num_req_p-1:0]                     rsp_ready_i
);

    localparam int lg_num_req_lp   = $clog2(num_req_p);
    localparam int lg_pkt_words_lp = (pkt_words_p > 1) ? $clog2(pkt_words_p) : 1;
    localparam int lg_rsp_words_lp = (rsp_words_p > 1) ? $clog2(rsp_words_p) : 1;

    typedef enum logic {e_idle, e_busy} state_e;

    state_e                     state_r;
    logic [lg_num_req_lp-1:0]   rr_ptr_r, gnt_r, scan_g, cur_g, q_head;
    logic [lg_pkt_words_lp-1:0] cnt_r;
    logic [lg_rsp_words_lp-1:0] rcnt_r;
    logic                       scan_v, busy, xfer, push, last_word;
    logic                       q_ready, q_v, rxfer, pop;

    // first eligible requester at or after rr_ptr_r; reads are skipped while the order queue is full
    always_comb begin
        scan_v = 1'b0;
        scan_g = '0;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            if (req_v_i[bp_rr_add(int'(rr_ptr_r), k, num_req_p)]
                && (!req_rsp_i[bp_rr_add(int'(rr_ptr_r), k, num_req_p)] || q_ready)) begin
                scan_v = 1'b1;
                scan_g = lg_num_req_lp'(bp_rr_add(int'(rr_ptr_r), k, num_req_p));
            end
        end
    end

    // command path: the grant is held for the whole packet, data passes straight through
    always_comb begin
        busy        = state_r == e_busy;
        cur_g       = busy ? gnt_r : scan_g;
        host_v_o    = ~reset_i & (busy ? req_v_i[gnt_r] : scan_v);
        host_data_o = req_data_i[int'(cur_g)*stream_data_width_p +: stream_data_width_p];
        xfer        = host_v_o & host_ready_and_i;
        req_yumi_o  = xfer ? (num_req_p'(1) << cur_g) : '0;
        push        = xfer & ~busy & req_rsp_i[cur_g];
        last_word   = cnt_r == lg_pkt_words_lp'(pkt_words_p - 1);
    end

    // packet FSM: IDLE grants on the scan, BUSY counts words until the packet is done
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r  <= e_idle;
            gnt_r    <= '0;
            cnt_r    <= '0;
            rr_ptr_r <= '0;
        end else if (xfer) begin
            if (!busy) begin
                if (pkt_words_p > 1) begin
                    state_r <= e_busy;
                    gnt_r   <= cur_g;
                    cnt_r   <= lg_pkt_words_lp'(1);
                end else begin
                    rr_ptr_r <= lg_num_req_lp'(bp_rr_inc(int'(cur_g), num_req_p));
                end
            end else if (last_word) begin
                rr_ptr_r <= lg_num_req_lp'(bp_rr_inc(int'(gnt_r), num_req_p));
                cnt_r    <= '0;
                state_r  <= e_idle;
            end else begin
                cnt_r <= cnt_r + 1'b1;
            end
        end
    end

    // response path: steer host words to the oldest outstanding reader
    always_comb begin
        rsp_v_o      = (host_v_i & q_v) ? (num_req_p'(1) << q_head) : '0;
        rsp_data_o   = host_data_i;
        host_ready_o = q_v & rsp_ready_i[q_head];
        rxfer        = host_v_i & host_ready_o;
        pop          = rxfer & (rcnt_r == lg_rsp_words_lp'(rsp_words_p - 1));
    end

    // response word counter; the queue entry retires with the final word
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            rcnt_r <= '0;
        else if (rxfer)
            rcnt_r <= pop ? '0 : rcnt_r + 1'b1;
    end

    bsg_fifo_1r1w_small #(
        .width_p(lg_num_req_lp),
        .els_p  (order_els_p)
    ) order_q (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .v_i    (push),
        .data_i (cur_g),
        .ready_o(q_ready),
        .v_o    (q_v),
        .data_o (q_head),
        .yumi_i (pop)
    );

endmodule

// File: tb/tb_bp_stream_mmio_arb.sv
// tb_bp_stream_mmio_arb: directed vector table plus hand-written multi-cycle sequences
module tb_bp_stream_mmio_arb;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [1:0]  req_v_i, req_rsp_i, req_yumi_o, rsp_v_o, rsp_ready_i;
    logic [63:0] req_data_i;
    logic        host_v_o, host_ready_and_i, host_v_i, host_ready_o;
    logic [31:0] host_data_o, host_data_i, rsp_data_o;

    int n_cmp = 0;
    int n_err = 0;

    bp_stream_mmio_arb dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .req_v_i         (req_v_i),
        .req_data_i      (req_data_i),
        .req_rsp_i       (req_rsp_i),
        .req_yumi_o      (req_yumi_o),
        .host_v_o        (host_v_o),
        .host_data_o     (host_data_o),
        .host_ready_and_i(host_ready_and_i),
        .host_v_i        (host_v_i),
        .host_data_i     (host_data_i),
        .host_ready_o    (host_ready_o),
        .rsp_v_o         (rsp_v_o),
        .rsp_data_o      (rsp_data_o),
        .rsp_ready_i     (rsp_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  rv, rsp;
        logic [31:0] d0, d1;
        logic        hrdy, hv;
        logic [31:0] hd;
        logic [1:0]  rrdy;
        logic        e_hv;
        logic [31:0] e_hd;
        logic [1:0]  e_yumi;
        logic        e_hready;
        logic [1:0]  e_rspv;
    } vec_t;

    vec_t vt[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] rv, input logic [1:0] rsp, input logic [31:0] d0,
                         input logic [31:0] d1, input logic hrdy, input logic hv,
                         input logic [31:0] hd, input logic [1:0] rrdy);
        req_v_i          = rv;
        req_rsp_i        = rsp;
        req_data_i       = {d1, d0};
        host_ready_and_i = hrdy;
        host_v_i         = hv;
        host_data_i      = hd;
        rsp_ready_i      = rrdy;
    endtask

    task automatic cyc(input logic [1:0] rv, input logic [1:0] rsp, input logic [31:0] d0,
                       input logic [31:0] d1, input logic hrdy, input logic hv,
                       input logic [31:0] hd, input logic [1:0] rrdy);
        @(negedge clk_i);
        drive(rv, rsp, d0, d1, hrdy, hv, hd, rrdy);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_i = 1'b1;
        drive(2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 0, 2'b00);
        @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    initial begin
        int ycnt;
        // outputs held at zero during reset even with every input active
        drive(2'b11, 2'b11, 32'h1, 32'h2, 1'b1, 1'b1, 32'h3, 2'b11);
        #3;
        chk("rst_host_v", 32'(host_v_o), 0);
        chk("rst_yumi", 32'(req_yumi_o), 0);
        chk("rst_host_ready", 32'(host_ready_o), 0);
        chk("rst_rsp_v", 32'(rsp_v_o), 0);
        @(negedge clk_i);
        reset_i = 1'b0;
        drive(2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 0, 2'b00);

        // rv rsp d0 d1 hrdy hv hd rrdy | e_hv e_hd e_yumi e_hready e_rspv
        vt[0]  = '{2'b11, 2'b00, 32'hA0, 32'hB0, 1'b1, 1'b0, 32'h0, 2'b11, 1'b1, 32'hA0, 2'b01, 1'b0, 2'b00};
        vt[1]  = '{2'b11, 2'b00, 32'hA1, 32'hB1, 1'b1, 1'b0, 32'h0, 2'b11, 1'b1, 32'hA1, 2'b01, 1'b0, 2'b00};
        vt[2]  = '{2'b11, 2'b00, 32'hA2, 32'hB2, 1'b1, 1'b0, 32'h0, 2'b11, 1'b1, 32'hB2, 2'b10, 1'b0, 2'b00};
        vt[3]  = '{2'b11, 2'b00, 32'hA3, 32'hB3, 1'b1, 1'b0, 32'h0, 2'b11, 1'b1, 32'hB3, 2'b10, 1'b0, 2'b00};
        vt[4]  = '{2'b11, 2'b00, 32'hA4, 32'hB4, 1'b1, 1'b0, 32'h0, 2'b11, 1'b1, 32'hA4, 2'b01, 1'b0, 2'b00};
        vt[5]  = '{2'b11, 2'b00, 32'hA5, 32'hB5, 1'b1, 1'b0, 32'h0, 2'b11, 1'b1, 32'hA5, 2'b01, 1'b0, 2'b00};
        vt[6]  = '{2'b11, 2'b00, 32'hA6, 32'hB6, 1'b1, 1'b0, 32'h0, 2'b11, 1'b1, 32'hB6, 2'b10, 1'b0, 2'b00};
        vt[7]  = '{2'b11, 2'b00, 32'hA7, 32'hB7, 1'b1, 1'b0, 32'h0, 2'b11, 1'b1, 32'hB7, 2'b10, 1'b0, 2'b00};
        vt[8]  = '{2'b01, 2'b00, 32'h8000_1000, 32'h0, 1'b1, 1'b0, 32'h0, 2'b11, 1'b1, 32'h8000_1000, 2'b01, 1'b0, 2'b00};
        vt[9]  = '{2'b01, 2'b00, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0, 32'h0, 2'b11, 1'b1, 32'hDEAD_BEEF, 2'b01, 1'b0, 2'b00};
        vt[10] = '{2'b10, 2'b10, 32'h0, 32'h11, 1'b1, 1'b0, 32'h0, 2'b11, 1'b1, 32'h11, 2'b10, 1'b0, 2'b00};
        vt[11] = '{2'b10, 2'b10, 32'h0, 32'h12, 1'b1, 1'b0, 32'h0, 2'b11, 1'b1, 32'h12, 2'b10, 1'b1, 2'b00};
        vt[12] = '{2'b01, 2'b01, 32'h21, 32'h0, 1'b1, 1'b1, 32'hA, 2'b11, 1'b1, 32'h21, 2'b01, 1'b1, 2'b10};
        vt[13] = '{2'b01, 2'b01, 32'h22, 32'h0, 1'b1, 1'b1, 32'hB, 2'b11, 1'b1, 32'h22, 2'b01, 1'b1, 2'b10};
        vt[14] = '{2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 32'hC, 2'b10, 1'b0, 32'h0, 2'b00, 1'b0, 2'b01};
        vt[15] = '{2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 32'hC, 2'b11, 1'b0, 32'h0, 2'b00, 1'b1, 2'b01};
        vt[16] = '{2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 32'hD, 2'b11, 1'b0, 32'h0, 2'b00, 1'b1, 2'b01};
        vt[17] = '{2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 32'hE, 2'b11, 1'b0, 32'h0, 2'b00, 1'b0, 2'b00};

        for (int i = 0; i < 18; i++) begin
            cyc(vt[i].rv, vt[i].rsp, vt[i].d0, vt[i].d1, vt[i].hrdy, vt[i].hv, vt[i].hd, vt[i].rrdy);
            chk($sformatf("v%0d_host_v", i), 32'(host_v_o), 32'(vt[i].e_hv));
            if (vt[i].e_hv)
                chk($sformatf("v%0d_host_data", i), host_data_o, vt[i].e_hd);
            chk($sformatf("v%0d_yumi", i), 32'(req_yumi_o), 32'(vt[i].e_yumi));
            chk($sformatf("v%0d_host_ready", i), 32'(host_ready_o), 32'(vt[i].e_hready));
            chk($sformatf("v%0d_rsp_v", i), 32'(rsp_v_o), 32'(vt[i].e_rspv));
            if (vt[i].e_rspv != 2'b00)
                chk($sformatf("v%0d_rsp_data", i), rsp_data_o, vt[i].hd);
        end

        // host back-pressure mid-packet: req0 keeps the link, req1 waits
        do_reset();
        cyc(2'b11, 2'b00, 32'hC0, 32'hD0, 1'b1, 1'b0, 0, 2'b11);
        chk("stall_first_yumi", 32'(req_yumi_o), 32'h1);
        chk("stall_first_data", host_data_o, 32'hC0);
        for (int i = 0; i < 5; i++) begin
            cyc(2'b11, 2'b00, 32'hC1, 32'hD0, 1'b0, 1'b0, 0, 2'b11);
            chk($sformatf("stall%0d_host_v", i), 32'(host_v_o), 32'h1);
            chk($sformatf("stall%0d_data", i), host_data_o, 32'hC1);
            chk($sformatf("stall%0d_yumi", i), 32'(req_yumi_o), 32'h0);
        end
        cyc(2'b11, 2'b00, 32'hC1, 32'hD0, 1'b1, 1'b0, 0, 2'b11);
        chk("stall_resume_yumi", 32'(req_yumi_o), 32'h1);
        chk("stall_resume_data", host_data_o, 32'hC1);
        cyc(2'b11, 2'b00, 32'hC2, 32'hD0, 1'b1, 1'b0, 0, 2'b11);
        chk("stall_next_yumi", 32'(req_yumi_o), 32'h2);
        chk("stall_next_data", host_data_o, 32'hD0);
        cyc(2'b11, 2'b00, 32'hC2, 32'hD1, 1'b1, 1'b0, 0, 2'b11);
        chk("stall_next2_yumi", 32'(req_yumi_o), 32'h2);
        chk("stall_next2_data", host_data_o, 32'hD1);

        // fill the order queue with 16 reads, then confirm reads block and writes pass
        do_reset();
        ycnt = 0;
        for (int i = 0; i < 32; i++) begin
            cyc(2'b01, 2'b01, 32'(i), 32'h0, 1'b1, 1'b0, 0, 2'b11);
            if (req_yumi_o == 2'b01)
                ycnt++;
        end
        chk("full_fill_yumis", 32'(ycnt), 32);
        cyc(2'b11, 2'b01, 32'h99, 32'h77, 1'b1, 1'b0, 0, 2'b11);
        chk("full_write_yumi", 32'(req_yumi_o), 32'h2);
        chk("full_write_data", host_data_o, 32'h77);
        cyc(2'b11, 2'b01, 32'h99, 32'h78, 1'b1, 1'b0, 0, 2'b11);
        chk("full_write2_yumi", 32'(req_yumi_o), 32'h2);
        chk("full_write2_data", host_data_o, 32'h78);
        cyc(2'b01, 2'b01, 32'h99, 32'h0, 1'b1, 1'b1, 32'h51, 2'b01);
        chk("full_rsp1_yumi", 32'(req_yumi_o), 32'h0);
        chk("full_rsp1_host_v", 32'(host_v_o), 32'h0);
        chk("full_rsp1_rsp_v", 32'(rsp_v_o), 32'h1);
        chk("full_rsp1_ready", 32'(host_ready_o), 32'h1);
        cyc(2'b01, 2'b01, 32'h99, 32'h0, 1'b1, 1'b1, 32'h52, 2'b01);
        chk("full_pop_cycle_yumi", 32'(req_yumi_o), 32'h0);
        cyc(2'b01, 2'b01, 32'h99, 32'h0, 1'b1, 1'b0, 0, 2'b01);
        chk("full_unblock_yumi", 32'(req_yumi_o), 32'h1);
        chk("full_unblock_data", host_data_o, 32'h99);

        // asynchronous reset in the middle of a req1 read packet
        do_reset();
        cyc(2'b01, 2'b00, 32'h31, 32'h0, 1'b1, 1'b0, 0, 2'b11);
        cyc(2'b01, 2'b00, 32'h32, 32'h0, 1'b1, 1'b0, 0, 2'b11);
        cyc(2'b10, 2'b10, 32'h0, 32'h41, 1'b1, 1'b0, 0, 2'b11);
        chk("ar_pre_yumi", 32'(req_yumi_o), 32'h2);
        cyc(2'b11, 2'b10, 32'h50, 32'h42, 1'b1, 1'b1, 32'h61, 2'b11);
        chk("ar_mid_yumi", 32'(req_yumi_o), 32'h2);
        chk("ar_mid_rsp_v", 32'(rsp_v_o), 32'h2);
        #1;
        reset_i = 1'b1;
        #1;
        chk("ar_host_v", 32'(host_v_o), 32'h0);
        chk("ar_yumi", 32'(req_yumi_o), 32'h0);
        chk("ar_host_ready", 32'(host_ready_o), 32'h0);
        chk("ar_rsp_v", 32'(rsp_v_o), 32'h0);
        @(negedge clk_i);
        reset_i = 1'b0;
        drive(2'b11, 2'b00, 32'h71, 32'h81, 1'b1, 1'b0, 0, 2'b11);
        #1;
        chk("ar_after_yumi", 32'(req_yumi_o), 32'h1);
        chk("ar_after_data", host_data_o, 32'h71);
        cyc(2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 0, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bp_stream_mmio_arb.md
# bp_stream_mmio_arb

Round-robin arbiter that shares one host-facing word stream between `num_req_p` stream MMIO bridges. Each bridge emits fixed-length command packets (address word, then data word). The arbiter forwards each packet atomically and records which requester expects a response. Returning host response words are steered back to that requester in issue order. It sits between the per-core stream MMIO bridges and the single FPGA host link.

## Interface
Parameters:
- `num_req_p`, 2: number of requesters; must be ≥ 2.
- `stream_data_width_p`, 32: width of one stream word.
- `pkt_words_p`, 2: words per command packet; must be ≥ 1.
- `rsp_words_p`, 2: words per response (64 b / 32 b).
- `order_els_p`, 16: depth of the response-order queue.

Ports:
- `clk_i`  in  1  sole clock.
- `reset_i`  in  1  asynchronous, active-high reset.
- `req_v_i`  in  `num_req_p`  requester word valid.
- `req_data_i`  in  `num_req_p*stream_data_width_p`  requester words; requester i occupies slice i.
- `req_rsp_i`  in  `num_req_p`  response expected; sampled only with the first word of a packet.
- `req_yumi_o`  out  `num_req_p`  word consumed.
- `host_v_o`  out  1  outgoing word valid.
- `host_data_o`  out  `stream_data_width_p`  outgoing word.
- `host_ready_and_i`  in  1  host accepts the word.
- `host_v_i`  in  1  response word valid.
- `host_data_i`  in  `stream_data_width_p`  response word.
- `host_ready_o`  out  1  response word accepted.
- `rsp_v_o`  out  `num_req_p`  response word valid, one-hot.
- `rsp_data_o`  out  `stream_data_width_p`  response word, shared by all requesters.
- `rsp_ready_i`  in  `num_req_p`  requester accepts the response word.

## Operation
Command FSM has two states, IDLE and BUSY.
- IDLE: grant goes to the first valid requester at or after `rr_ptr_r`, scanning upward with wrap.
  - A grant to a read (`req_rsp_i` high) is legal only if the order queue is not full.
  - The granted requester's word drives `host_data_o`, and `host_v_o` is asserted.
  - On `host_ready_and_i`, pulse `req_yumi_o[g]`. If `req_rsp_i[g]` is set, push g into the order queue.
  - If `pkt_words_p` > 1: latch g in `gnt_r`, set `cnt_r` = 1, go to BUSY. Otherwise apply the pointer update immediately.
- BUSY: only `gnt_r` is forwarded; no other requester may interleave.
  - Each accepted word increments `cnt_r`.
  - On the word where `cnt_r` = `pkt_words_p`-1: `rr_ptr_r` ← (`gnt_r`+1) mod `num_req_p`, `cnt_r` ← 0, go to IDLE.
- `req_yumi_o[i]` = `host_v_o` & `host_ready_and_i` & (i is granted). A yumi never asserts without a valid input word.

Response path:
- h = head of the order queue.
- `rsp_v_o[h]` = `host_v_i` & queue non-empty.
- `host_ready_o` = queue non-empty & `rsp_ready_i[h]`.
- Each transfer increments `rcnt_r`. At `rsp_words_p` words, pop the queue and clear `rcnt_r`.
- If the queue is empty, `host_ready_o` = 0 and the host stalls. No word is dropped.

Boundary conditions:
- Full queue: a read packet cannot start, even in a cycle where the queue pops. Its readiness comes from registered state. Write packets proceed.
- Push and pop in the same cycle are legal when the queue is not full.
- A requester whose `req_v_i` drops mid-packet only stalls the link; the grant is held.
- `rr_ptr_r` wraps from `num_req_p`-1 to 0.
- Reset, including mid-packet: FSM → IDLE, and `rr_ptr_r`, `cnt_r`, `rcnt_r` and the queue are all cleared. In-flight packets are abandoned; the requesters are reset too.

## Timing
- Output values while `reset_i` is asserted:
  - `host_v_o`, `req_yumi_o`, `rsp_v_o`, `host_ready_o` are 0.
  - `host_data_o` and `rsp_data_o` are don't-care.
- Request to host: zero latency, combinational pass-through. Throughput is one word per cycle.
- Back-to-back packets: IDLE grants in the same cycle the previous packet's last word transfers, so there are no bubbles between packets.
- Response: zero latency, host to requester, combinational.
- The first response word can be returned in the cycle after the command word that pushed the queue entry.
- Handshakes:
  - Request side is valid/yumi.
  - Host side is ready-and-valid in both directions.

## Structure
- Sub-module `bsg_fifo_1r1w_small`: width `$clog2(num_req_p)`, depth `order_els_p`; holds the order queue.
- Round-robin scan is inline logic.
- No new package typedefs. Local widths: `lg_num_req_lp` = `$clog2(num_req_p)`, `lg_pkt_words_lp`, `lg_rsp_words_lp`.

## Test plan
- Write on req0 only (`req_rsp_i` = 0), words 0x8000_1000 then 0xDEAD_BEEF: host sees both words on consecutive cycles; no queue push; `host_ready_o` stays 0.
- Both requesters continuously valid after reset with 4 packets total: host order is req0, req1, req0, req1, with each pair of words contiguous.
- Read on req1, then read on req0; host returns words 0xA, 0xB, 0xC, 0xD: `rsp_v_o[1]` receives 0xA, 0xB and `rsp_v_o[0]` receives 0xC, 0xD.
- `host_ready_and_i` = 0 for 5 cycles after the first word of a req0 packet while req1 is valid: req0's second word is the next word sent; req1 starts only afterwards.
- 16 outstanding reads on req0 (queue full): the 17th read is not yumied and a req1 write still proceeds. One completed response (2 words) unblocks the read the next cycle.
- Assert `reset_i` asynchronously mid-packet: all outputs go to 0 immediately. After release, req1 and req0 both valid → req0 is granted first.
